pov_frame_player: RTL

Parametrised angle-indexed pattern player for the POV LED fan. It tracks blade angle from `fanclk` step edges and an optional once-per-revolution `index` marker, and drives `led` from a writable pattern RAM holding `NUM_FRAMES` full-revolution images. It auto-advances frames every `REVS_PER_FRAME` revolutions. It replaces the hard-coded per-angle LED decode blocks and sits between the fan sensor inputs and the LED driver pins.

---
 rtl/pov_frame_player_pkg.sv | 22 ++
 rtl/pov_frame_player_if.sv | 29 ++
 rtl/pov_pattern_ram.sv | 28 ++
 rtl/pov_frame_player.sv | 107 ++++++++++
 4 files changed

// File: rtl/pov_frame_player_pkg.sv
// Shared widths and default geometry for the POV fan pattern player.
package pov_pkg;

   localparam int DEF_NUM_LEDS       = 16;
   localparam int DEF_DEG_STEPS      = 360;
   localparam int DEF_NUM_FRAMES     = 4;
   localparam int DEF_REVS_PER_FRAME = 8;

   // deg runs DEG_STEPS..1, so it needs room for DEG_STEPS itself
   function automatic int deg_width(input int steps);
      return $clog2(steps + 1);
   endfunction

   function automatic int frame_width(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pov_frame_player_if.sv
// Sensor, pattern-write and LED-drive signals of the POV frame player.
interface pov_frame_player_if import pov_pkg::*; #(
   parameter int NUM_LEDS = DEF_NUM_LEDS,
   parameter int DEG_W    = deg_width(DEF_DEG_STEPS),
   parameter int FRAME_W  = frame_width(DEF_NUM_FRAMES)
) ();

   logic                fanclk;
   logic                index;
   logic                wr_en;
   logic [FRAME_W-1:0]  wr_frame;
   logic [DEG_W-1:0]    wr_deg;
   logic [NUM_LEDS-1:0] wr_data;
   logic [NUM_LEDS-1:0] led;
   logic [DEG_W-1:0]    deg;
   logic [FRAME_W-1:0]  frame;
   logic                rev_pulse;

   modport master (
      output fanclk, index, wr_en, wr_frame, wr_deg, wr_data,
      input  led, deg, frame, rev_pulse
   );

   modport slave (
      input  fanclk, index, wr_en, wr_frame, wr_deg, wr_data,
      output led, deg, frame, rev_pulse
   );

endinterface

// File: rtl/pov_pattern_ram.sv
// Simple dual-port pattern RAM: one write port, one registered read-first read port.
module pov_pattern_ram #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 1440,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // contents are deliberately left out of reset so patterns survive rst
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pov_frame_player.sv
// Angle-indexed POV pattern player: tracks blade angle from fanclk/index and plays stored frames.
module pov_frame_player import pov_pkg::*; #(
   parameter int NUM_LEDS       = DEF_NUM_LEDS,
   parameter int DEG_STEPS      = DEF_DEG_STEPS,
   parameter int NUM_FRAMES     = DEF_NUM_FRAMES,
   parameter int REVS_PER_FRAME = DEF_REVS_PER_FRAME
) (
   input logic               clk,
   input logic               rst,
   pov_frame_player_if.slave bus
);

   localparam int DEG_W   = deg_width(DEG_STEPS);
   localparam int FRAME_W = frame_width(NUM_FRAMES);
   localparam int DEPTH   = NUM_FRAMES * DEG_STEPS;
   localparam int ADDR_W  = addr_width(DEPTH);
   localparam int REV_W   = (REVS_PER_FRAME > 1) ? $clog2(REVS_PER_FRAME) : 1;

   localparam logic [DEG_W-1:0]   DEG_MAX    = DEG_W'(DEG_STEPS);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [REV_W-1:0]   REV_LAST   = REV_W'(REVS_PER_FRAME - 1);

   logic                fanclk_q;
   logic                index_q;
   logic                step;
   logic                sync;
   logic                wrap;
   logic                boundary;
   logic                moved;
   logic [DEG_W-1:0]    deg_r;
   logic [FRAME_W-1:0]  frame_r;
   logic [REV_W-1:0]    rev_cnt;
   logic                rev_pulse_r;
   logic                frame_ok;
   logic                wr_ok;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ADDR_W-1:0]   rd_addr;
   logic [NUM_LEDS-1:0] ram_q;

   assign step = bus.fanclk & ~fanclk_q;
   assign sync = bus.index & ~index_q;
   // a sync in the same cycle as the last step already reloads, so it is one boundary
   assign wrap     = step & ~sync & (deg_r == DEG_W'(1));
   assign boundary = (sync | wrap) & moved;

   always_ff @(posedge clk) begin
      if (rst) begin
         fanclk_q    <= 1'b0;
         index_q     <= 1'b0;
         deg_r       <= DEG_MAX;
         frame_r     <= '0;
         rev_cnt     <= '0;
         rev_pulse_r <= 1'b0;
         moved       <= 1'b0;
      end else begin
         fanclk_q    <= bus.fanclk;
         index_q     <= bus.index;
         rev_pulse_r <= boundary;

         if (sync)      deg_r <= DEG_MAX;
         else if (step) deg_r <= (deg_r == DEG_W'(1)) ? DEG_MAX : deg_r - DEG_W'(1);

         if (boundary)  moved <= 1'b0;
         else if (step) moved <= 1'b1;

         if (boundary) begin
            if (rev_cnt == REV_LAST) begin
               rev_cnt <= '0;
               frame_r <= (frame_r == FRAME_LAST) ? '0 : frame_r + FRAME_W'(1);
            end else begin
               rev_cnt <= rev_cnt + REV_W'(1);
            end
         end
      end
   end

   // when NUM_FRAMES fills the frame field every encoding is a legal frame
   if (NUM_FRAMES == (1 << FRAME_W)) begin : g_frame_full
      assign frame_ok = 1'b1;
   end else begin : g_frame_part
      assign frame_ok = (bus.wr_frame <= FRAME_LAST);
   end

   assign wr_ok   = bus.wr_en & frame_ok & (bus.wr_deg != '0) & (bus.wr_deg <= DEG_MAX);
   assign wr_addr = ADDR_W'(32'(bus.wr_frame) * 32'(DEG_STEPS) + 32'(bus.wr_deg) - 32'd1);
   assign rd_addr = ADDR_W'(32'(frame_r) * 32'(DEG_STEPS) + 32'(deg_r) - 32'd1);

   pov_pattern_ram #(
      .WIDTH  (NUM_LEDS),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   assign bus.led       = ram_q;
   assign bus.deg       = deg_r;
   assign bus.frame     = frame_r;
   assign bus.rev_pulse = rev_pulse_r;

endmodule
